// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - issue-side register-file hazard scoreboard
//
// Tracks per-register pending-write counts and grants in-order issue lanes
// whose sources carry no outstanding write.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   iss_valid/rs1/rs2/rd/rd_we  per-lane issue request (lane 0 oldest)
//   iss_ready           per-lane grant, combinational
//   wb_valid/wb_rd      write-back completions
//   flush               clear all pending writes
//   busy                bit r set while register r has pending writes
//   stall_cycles        cycles with lane 0 valid but not ready
//   err                 sticky: write-back with nothing pending
//
// Optional feature: define RF_SCOREBOARD_BYPASS_EN to let same-cycle
// write-backs clear source hazards (RF write forwarding).
module rf_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter int ISSUE_WIDTH = 2,
  parameter int WB_PORTS    = 1,
  parameter int CNT_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ISSUE_WIDTH-1:0] iss_valid,
  input  logic [ADDR_WIDTH-1:0]  iss_rs1 [ISSUE_WIDTH-1:0],
  input  logic [ADDR_WIDTH-1:0]  iss_rs2 [ISSUE_WIDTH-1:0],
  input  logic [ADDR_WIDTH-1:0]  iss_rd  [ISSUE_WIDTH-1:0],
  input  logic [ISSUE_WIDTH-1:0] iss_rd_we,
  output logic [ISSUE_WIDTH-1:0] iss_ready,
  input  logic [WB_PORTS-1:0]    wb_valid,
  input  logic [ADDR_WIDTH-1:0]  wb_rd [WB_PORTS-1:0],
  input  logic                   flush,
  output logic [NUM_REGS-1:0]    busy,
  output logic [31:0]            stall_cycles,
  output logic                   err
);

  localparam int CNT_MAX = (1 << CNT_WIDTH) - 1;

  logic [CNT_WIDTH-1:0] cnt     [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_REGS];
  logic                 err_nxt;

  always_comb begin : ready_logic
    int   pend1;
    int   pend2;
    int   older;
    logic ok;
    logic in_order;
    in_order  = 1'b1;
    iss_ready = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      pend1 = int'(cnt[iss_rs1[k]]);
      pend2 = int'(cnt[iss_rs2[k]]);
`ifdef RF_SCOREBOARD_BYPASS_EN
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && wb_rd[p] == iss_rs1[k]) pend1 = pend1 - 1;
        if (wb_valid[p] && wb_rd[p] == iss_rs2[k]) pend2 = pend2 - 1;
      end
`endif
      ok = in_order & iss_valid[k];
      if (iss_rs1[k] != '0 && pend1 > 0) ok = 1'b0;
      if (iss_rs2[k] != '0 && pend2 > 0) ok = 1'b0;
      // Intra-bundle RAW against older lanes' destinations.
      older = 0;
      for (int j = 0; j < k; j++) begin
        if (iss_rd_we[j] && iss_rd[j] != '0 &&
            (iss_rd[j] == iss_rs1[k] || iss_rd[j] == iss_rs2[k])) ok = 1'b0;
        if (iss_valid[j] && iss_rd_we[j] && iss_rd[j] == iss_rd[k]) older = older + 1;
      end
      // Saturation uses the registered count only: a slot freed by a
      // same-cycle write-back is not handed out until the next cycle.
      if (iss_rd_we[k] && iss_rd[k] != '0 &&
          int'(cnt[iss_rd[k]]) + older >= CNT_MAX) ok = 1'b0;
      iss_ready[k] = ok;
      in_order     = ok;
    end
  end

  always_comb begin : next_state
    int inc;
    int dec;
    int total;
    err_nxt = err;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc = 0;
      dec = 0;
      for (int k = 0; k < ISSUE_WIDTH; k++)
        if (iss_ready[k] && iss_rd_we[k] && iss_rd[k] == ADDR_WIDTH'(r)) inc = inc + 1;
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p] && wb_rd[p] == ADDR_WIDTH'(r)) dec = dec + 1;
      total = int'(cnt[r]) + inc - dec;
      if (r == 0 || flush) begin
        total = 0;
      end else if (total < 0) begin
        // Excess write-backs are dropped rather than underflowing.
        total   = 0;
        err_nxt = 1'b1;
      end
      cnt_nxt[r] = CNT_WIDTH'(total);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      stall_cycles <= '0;
      err          <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      if (iss_valid[0] && !iss_ready[0]) stall_cycles <= stall_cycles + 32'd1;
      err <= err_nxt;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - self-checking bench for rf_scoreboard
module tb_rf_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] iss_valid, iss_rd_we, iss_ready;
  logic [4:0] iss_rs1 [1:0];
  logic [4:0] iss_rs2 [1:0];
  logic [4:0] iss_rd  [1:0];
  logic [0:0] wb_valid;
  logic [4:0] wb_rd [0:0];
  logic       flush;
  logic [31:0] busy;
  logic [31:0] stall_cycles;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  rf_scoreboard dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_rd_we(iss_rd_we), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy(busy), .stall_cycles(stall_cycles), .err(err)
  );

  always #5 clk = ~clk;

`ifdef RF_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference model: plain pending-write counts per register.
  int          mcnt [32];
  bit          merr = 1'b0;
  logic [31:0] mstall = '0;
  bit          model_ok = 1'b0;

  function automatic bit src_ok(logic [4:0] s);
    int pend;
    pend = mcnt[s];
    if (BYP && wb_valid[0] && wb_rd[0] == s) pend = pend - 1;
    return (s == 5'd0) || (pend <= 0);
  endfunction

  function automatic logic [1:0] m_ready();
    logic [1:0] r;
    bit prev;
    bit ok;
    int n;
    r = '0;
    prev = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ok = prev && iss_valid[k] && src_ok(iss_rs1[k]) && src_ok(iss_rs2[k]);
      n = mcnt[iss_rd[k]];
      for (int j = 0; j < k; j++) begin
        if (iss_rd_we[j] && iss_rd[j] != 0 && (iss_rd[j] == iss_rs1[k] || iss_rd[j] == iss_rs2[k]))
          ok = 1'b0;
        if (iss_rd_we[j] && iss_rd[j] == iss_rd[k]) n++;
      end
      if (iss_rd_we[k] && iss_rd[k] != 0 && n >= 3) ok = 1'b0;
      r[k] = ok;
      prev = ok;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  always @(posedge clk) begin
    logic [1:0] r;
    r = m_ready();
    if (rst) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      merr = 1'b0;
      mstall = '0;
      model_ok = 1'b1;
    end else begin
      if (iss_valid[0] && !r[0]) mstall = mstall + 1;
      if (flush) begin
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
      end else begin
        for (int k = 0; k < 2; k++)
          if (r[k] && iss_rd_we[k] && iss_rd[k] != 0) mcnt[iss_rd[k]]++;
        if (wb_valid[0] && wb_rd[0] != 0) begin
          if (mcnt[wb_rd[0]] > 0) mcnt[wb_rd[0]]--;
          else merr = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle once the model is synchronised by reset.
  always @(negedge clk) begin
    if (model_ok) begin
      n_tests += 4;
      if (iss_ready !== m_ready()) begin
        n_fail++;
        $display("FAIL model_ready t=%0t got %b want %b", $time, iss_ready, m_ready());
      end
      if (busy !== m_busy()) begin
        n_fail++;
        $display("FAIL model_busy t=%0t got %h want %h", $time, busy, m_busy());
      end
      if (stall_cycles !== mstall) begin
        n_fail++;
        $display("FAIL model_stall t=%0t got %0d want %0d", $time, stall_cycles, mstall);
      end
      if (err !== merr) begin
        n_fail++;
        $display("FAIL model_err t=%0t got %b want %b", $time, err, merr);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    iss_valid = '0;
    iss_rd_we = '0;
    for (int k = 0; k < 2; k++) begin
      iss_rs1[k] = '0; iss_rs2[k] = '0; iss_rd[k] = '0;
    end
    wb_valid = '0;
    wb_rd[0] = '0;
    flush = 1'b0;
  endtask

  task automatic lane(int k, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic we);
    iss_valid[k] = 1'b1;
    iss_rs1[k] = rs1; iss_rs2[k] = rs2; iss_rd[k] = rd; iss_rd_we[k] = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("reset_busy", busy, 32'h0);
    chk("reset_stall", stall_cycles, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);

    // RAW on r5 across cycles
    lane(0, 0, 0, 5, 1);
    #1 chk("issue_rd5", {30'h0, iss_ready}, 32'h1);
    tick();
    idle(); lane(0, 5, 0, 0, 0);
    #1 chk("raw_stall", {30'h0, iss_ready}, 32'h0);
    chk("busy5", busy, 32'h20);
    chk("stall0", stall_cycles, 32'd0);
    tick();
    chk("stall1", stall_cycles, 32'd1);
    wb_valid = 1'b1; wb_rd[0] = 5;
    #1 chk("wb_same_cycle", {30'h0, iss_ready}, BYP ? 32'h1 : 32'h0);
    tick();
    wb_valid = 1'b0;
    #1 chk("after_wb_ready", {30'h0, iss_ready}, 32'h1);
    chk("after_wb_busy", busy, 32'h0);
    chk("after_wb_stall", stall_cycles, BYP ? 32'd1 : 32'd2);
    tick();

    // Intra-bundle RAW and r0 handling
    idle(); lane(0, 0, 0, 3, 1); lane(1, 0, 3, 0, 0);
    #1 chk("bundle_raw", {30'h0, iss_ready}, 32'h1);
    iss_rd[0] = 0; iss_rs2[1] = 0;
    #1 chk("bundle_r0", {30'h0, iss_ready}, 32'h3);
    tick();
    chk("r0_not_busy", busy, 32'h0);

    // In-order blocking
    idle(); lane(0, 0, 0, 4, 1);
    tick();
    idle(); lane(0, 4, 0, 0, 0); lane(1, 1, 2, 0, 0);
    #1 chk("in_order", {30'h0, iss_ready}, 32'h0);
    idle(); wb_valid = 1'b1; wb_rd[0] = 4;
    tick();

    // Saturation on r7
    idle();
    for (int i = 0; i < 3; i++) begin
      lane(0, 0, 0, 7, 1);
      #1 chk("sat_issue", {30'h0, iss_ready}, 32'h1);
      tick();
    end
    #1 chk("sat_full", {30'h0, iss_ready}, 32'h0);
    wb_valid = 1'b1; wb_rd[0] = 7;
    #1 chk("sat_no_reuse", {30'h0, iss_ready}, 32'h0);
    tick();
    wb_valid = 1'b0;
    #1 chk("sat_freed", {30'h0, iss_ready}, 32'h1);
    tick();
    idle(); wb_valid = 1'b1; wb_rd[0] = 7;
    tick(); tick(); tick();
    idle();
    #1 chk("sat_drained", busy, 32'h0);

    // Spurious write-back
    wb_valid = 1'b1; wb_rd[0] = 9;
    tick();
    idle();
    #1 chk("err_set", {31'h0, err}, 32'h1);
    chk("err_cnt9", busy, 32'h0);
    tick();
    chk("err_sticky", {31'h0, err}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("err_cleared", {31'h0, err}, 32'h0);

    // Flush with same-cycle fire
    lane(0, 0, 0, 1, 1); lane(1, 0, 0, 2, 1);
    tick();
    chk("pre_flush_busy", busy, 32'h6);
    idle(); lane(0, 0, 0, 10, 1); flush = 1'b1;
    #1 chk("flush_ready", {30'h0, iss_ready}, 32'h1);
    tick();
    idle();
    #1 chk("flush_busy", busy, 32'h0);

    // Randomised phase, checked by the compare process
    for (int c = 0; c < 4000; c++) begin
      idle();
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 3) != 0)
          lane(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        wb_valid = 1'b1;
        wb_rd[0] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 19) != 0)
          for (int i = 1; i < 8; i++)
            if (mcnt[i] > 0) wb_rd[0] = 5'(i);
      end
      tick();
    end
    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
